// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, stall/redirect handling.
// Optional stall counter enabled by defining FETCH_STALL_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        If_Id_Write,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] Instr_in,
  output logic [31:0] PC,
  output logic [31:0] If_Id_PC4,
  output logic [31:0] If_Id_Instr,
  output logic [4:0]  If_Id_rs,
  output logic [4:0]  If_Id_rt,
  output logic        If_Id_Valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] Stall_Count
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect;

  // Word-aligned targets drop the low address bits.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^{BranchTarget[1:0], JumpTarget[1:0]};

  assign redirect = BranchTaken | Jump;
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-PC selection: redirect beats stall.
  always_comb begin
    pc_d = pc_plus4;
    if (BranchTaken) begin
      pc_d = {BranchTarget[31:2], 2'b00};
    end else if (Jump) begin
      pc_d = {JumpTarget[31:2], 2'b00};
    end else if (!PCWrite) begin
      pc_d = pc_q;
    end
  end

  // IF/ID next state: flush on redirect, else hold or load.
  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (If_Id_Write) begin
      pc4_d   = pc_plus4;
      instr_d = Instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign PC          = pc_q;
  assign If_Id_PC4   = pc4_q;
  assign If_Id_Instr = instr_q;
  assign If_Id_Valid = valid_q;
  assign If_Id_rs    = instr_q[25:21];
  assign If_Id_rt    = instr_q[20:16];

`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of stalled, non-redirected edges.
  always_comb begin
    cnt_d = cnt_q;
    if (!PCWrite && !redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Stall_Count = cnt_q;
`else
  localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage (RESET_PC = 0x40).
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        PCWrite, If_Id_Write, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget, Instr_in;
  logic [31:0] PC, If_Id_PC4, If_Id_Instr;
  logic [4:0]  If_Id_rs, If_Id_rt;
  logic        If_Id_Valid;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] Stall_Count;
`endif

  if_fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
    .clk(clk), .rst_n(rst_n),
    .PCWrite(PCWrite), .If_Id_Write(If_Id_Write),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Instr_in(Instr_in),
    .PC(PC), .If_Id_PC4(If_Id_PC4), .If_Id_Instr(If_Id_Instr),
    .If_Id_rs(If_Id_rs), .If_Id_rt(If_Id_rt), .If_Id_Valid(If_Id_Valid)
`ifdef FETCH_STALL_CNT_EN
    , .Stall_Count(Stall_Count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcw, ifw, br, jmp;
    logic [31:0] brt, jt, instr;
    logic [31:0] e_pc, e_pc4, e_instr;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[14];
  int   n_vec;
  int   n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, PC, 32'h0000_0040);
    chk({tag, "_pc4"}, If_Id_PC4, 32'h0);
    chk({tag, "_instr"}, If_Id_Instr, 32'h0);
    chk({tag, "_valid"}, 32'(If_Id_Valid), 32'h0);
    chk({tag, "_rs"}, 32'(If_Id_rs), 32'h0);
    chk({tag, "_rt"}, 32'(If_Id_rt), 32'h0);
`ifdef FETCH_STALL_CNT_EN
    chk({tag, "_cnt"}, 32'(Stall_Count), 32'h0);
`endif
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic br, input logic [31:0] brt,
                       input logic jmp, input logic [31:0] jt, input logic [31:0] instr);
    PCWrite = pcw; If_Id_Write = ifw; BranchTaken = br; BranchTarget = brt;
    Jump = jmp; JumpTarget = jt; Instr_in = instr;
  endtask

  function automatic vec_t mk(input logic pcw, input logic ifw, input logic br, input logic [31:0] brt,
                              input logic jmp, input logic [31:0] jt, input logic [31:0] instr,
                              input logic [31:0] e_pc, input logic [31:0] e_pc4,
                              input logic [31:0] e_instr, input logic e_valid, input logic [15:0] e_cnt);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.br = br; v.brt = brt; v.jmp = jmp; v.jt = jt; v.instr = instr;
    v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr; v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    // pcw ifw br brt jmp jt instr | pc pc4 instr valid cnt
    vecs[0]  = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h8C22_0004, 32'h44, 32'h44, 32'h8C22_0004, 1, 0);
    vecs[1]  = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h0043_1820, 32'h48, 32'h48, 32'h0043_1820, 1, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 32'h48, 32'h48, 32'h0043_1820, 1, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 32'h48, 32'h48, 32'h0043_1820, 1, 2);
    vecs[4]  = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h1111_2222, 32'h4C, 32'h4C, 32'h1111_2222, 1, 2);
    vecs[5]  = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h2222_3333, 32'h50, 32'h50, 32'h2222_3333, 1, 2);
    vecs[6]  = mk(1, 1, 0, 32'h0, 1, 32'h203, 32'h3333_4444, 32'h200, 32'h0, 32'h0, 0, 2);
    vecs[7]  = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h4444_5555, 32'h204, 32'h204, 32'h4444_5555, 1, 2);
    vecs[8]  = mk(0, 0, 1, 32'h100, 1, 32'h200, 32'h5555_6666, 32'h100, 32'h0, 32'h0, 0, 2);
    vecs[9]  = mk(1, 0, 0, 32'h0, 0, 32'h0, 32'h7777_8888, 32'h104, 32'h0, 32'h0, 0, 2);
    vecs[10] = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h6666_7777, 32'h108, 32'h108, 32'h6666_7777, 1, 2);
    vecs[11] = mk(1, 1, 1, 32'hFFFF_FFFE, 0, 32'h0, 32'h9999_0000, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 2);
    vecs[12] = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h0123_4567, 32'h0, 32'h0, 32'h0123_4567, 1, 2);
    vecs[13] = mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h89AB_CDEF, 32'h4, 32'h4, 32'h89AB_CDEF, 1, 2);

    rst_n = 1'b0;
    drive(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk_reset_state("reset");

    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].pcw, vecs[i].ifw, vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jt, vecs[i].instr);
      @(negedge clk);
      chk($sformatf("v%0d_pc", i), PC, vecs[i].e_pc);
      chk($sformatf("v%0d_pc4", i), If_Id_PC4, vecs[i].e_pc4);
      chk($sformatf("v%0d_instr", i), If_Id_Instr, vecs[i].e_instr);
      chk($sformatf("v%0d_valid", i), 32'(If_Id_Valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_rs", i), 32'(If_Id_rs), 32'(vecs[i].e_instr[25:21]));
      chk($sformatf("v%0d_rt", i), 32'(If_Id_rt), 32'(vecs[i].e_instr[20:16]));
`ifdef FETCH_STALL_CNT_EN
      chk($sformatf("v%0d_cnt", i), 32'(Stall_Count), 32'(vecs[i].e_cnt));
`endif
    end
    chk("v0_rs_lit", 32'(vecs[0].e_instr[25:21]), 32'd1);

    // Asynchronous reset mid-cycle during a stall, no clock edge involved.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");

    // A redirect seen only while in reset must not survive it.
    drive(1, 1, 1, 32'h300, 1, 32'h400, 32'hAAAA_0001);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 32'h0, 0, 32'h0, 32'hAAAA_0001);
    @(negedge clk);
    chk("post_rst_pc", PC, 32'h44);
    chk("post_rst_instr", If_Id_Instr, 32'hAAAA_0001);
    chk("post_rst_valid", 32'(If_Id_Valid), 32'h1);

`ifdef FETCH_STALL_CNT_EN
    // Counter saturates rather than wrapping.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    repeat (65540) @(negedge clk);
    chk("cnt_sat", 32'(Stall_Count), 32'h0000_FFFF);
    chk("cnt_sat_pc", PC, 32'h44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
